// File: rtl/ejtag_dclk_pkg.sv
// -----------------------------------------------------------------------------
// ejtag_dclk_pkg
// Shared definitions for the EJTAG debug-clock generator:
//   - dclk_state_e : generator state encoding (IDLE / RUN / DRAIN)
//   - hi_phase_len : number of high DCLK phases, ceil(N/2), from N-1
// -----------------------------------------------------------------------------
package ejtag_dclk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } dclk_state_e;

   // ceil(N/2) with N = nminus1 + 1, i.e. (nminus1 + 2) / 2. Evaluated at a
   // fixed 32-bit width so callers with any ratio width can share it.
   function automatic logic [31:0] hi_phase_len(input logic [31:0] nminus1);
      return (nminus1 + 32'd2) >> 1;
   endfunction

endpackage

// File: rtl/ejtag_dclk_phcnt.sv
// -----------------------------------------------------------------------------
// ejtag_dclk_phcnt
// Phase counter for the debug-clock generator. Counts 0..N-1 while the
// generator is active, flags the last phase of a period (wrap) and produces
// the registered DCLK level and data-ready strobe for the next cycle.
// Ports:
//   clk, rst_n  : core clock, synchronous active-low reset
//   active_i    : generator currently in RUN or DRAIN
//   run_i       : generator will be in RUN or DRAIN after this edge
//   nm1_cur_i   : ratio-1 in force for the current period
//   nm1_nxt_i   : ratio-1 in force for the cycle after this edge
//   wrap_o      : current cycle is the last phase of the period
//   dclk_o      : registered debug clock
//   dren_o      : registered last-phase strobe
// -----------------------------------------------------------------------------
module ejtag_dclk_phcnt
   import ejtag_dclk_pkg::*;
#(
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          active_i,
   input  logic          run_i,
   input  logic [RW-1:0] nm1_cur_i,
   input  logic [RW-1:0] nm1_nxt_i,
   output logic          wrap_o,
   output logic          dclk_o,
   output logic          dren_o
);

   localparam logic [RW-1:0] PH_ONE = {{(RW-1){1'b0}}, 1'b1};

   logic [RW-1:0] ph_q, ph_d;
   logic          dclk_q, dclk_d;
   logic          dren_q, dren_d;

   assign wrap_o = active_i && (ph_q == nm1_cur_i);
   assign dclk_o = dclk_q;
   assign dren_o = dren_q;

   // Next phase and the DCLK/DREN levels that belong to that phase.
   always_comb begin
      ph_d   = ph_q;
      dclk_d = 1'b0;
      dren_d = 1'b0;
      // A new period (start from idle or wrap) and stopping both land on 0.
      if (!run_i || !active_i || wrap_o) begin
         ph_d = {RW{1'b0}};
      end else begin
         ph_d = ph_q + PH_ONE;
      end
      if (run_i) begin
         dclk_d = (32'(ph_d) < hi_phase_len(32'(nm1_nxt_i)));
         dren_d = (ph_d == nm1_nxt_i);
      end else begin
         dclk_d = 1'b0;
         dren_d = 1'b0;
      end
   end

   // Phase and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph_q   <= {RW{1'b0}};
         dclk_q <= 1'b0;
         dren_q <= 1'b0;
      end else begin
         ph_q   <= ph_d;
         dclk_q <= dclk_d;
         dren_q <= dren_d;
      end
   end

endmodule

// File: rtl/ejtag_dclk_gen.sv
// -----------------------------------------------------------------------------
// ejtag_dclk_gen
// EJTAG debug-clock generator. Divides CLK by N = ratio+1 (2..2^RW) into a
// glitch-free registered DCLK, with a last-phase strobe, ratio changes applied
// only at period boundaries, graceful start/stop and a completed-period count.
// Ports:
//   CLK            : core clock
//   RESET_D1_R_N   : synchronous active-low reset
//   EN             : run request
//   CFG_NMINUS1    : new ratio minus one, taken when CFG_LOAD=1
//   CFG_LOAD       : apply CFG_NMINUS1 at the next boundary
//   EJT_DCLK_R     : divided debug clock
//   EJT_DREN_R     : high in the last CLK cycle of each DCLK period
//   CFG_ACK_R      : one-cycle pulse when a loaded ratio takes effect
//   CFG_ERR_R      : sticky, set by a CFG_NMINUS1=0 load
//   BUSY_R         : running or draining
//   PERIOD_CNT_R   : completed DCLK periods, wrapping
// -----------------------------------------------------------------------------
module ejtag_dclk_gen
   import ejtag_dclk_pkg::*;
#(
   parameter int unsigned    RW          = 4,
   parameter int unsigned    CW          = 16,
   parameter logic [RW-1:0]  RST_NMINUS1 = {RW{1'b1}}
) (
   input  logic          CLK,
   input  logic          RESET_D1_R_N,
   input  logic          EN,
   input  logic [RW-1:0] CFG_NMINUS1,
   input  logic          CFG_LOAD,
   output logic          EJT_DCLK_R,
   output logic          EJT_DREN_R,
   output logic          CFG_ACK_R,
   output logic          CFG_ERR_R,
   output logic          BUSY_R,
   output logic [CW-1:0] PERIOD_CNT_R
);

   localparam logic [RW-1:0] NM1_MIN = {{(RW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   dclk_state_e   state_q, state_d;
   logic [RW-1:0] nm1_q, nm1_d;
   logic [RW-1:0] pval_q, pval_d;
   logic          pend_q, pend_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] pcnt_q, pcnt_d;

   logic          wrap_s;
   logic          cfg_zero_s;
   logic [RW-1:0] cfg_fix_s;

   // A zero ratio would give a one-cycle period; it is forced to N=2.
   assign cfg_zero_s = (CFG_NMINUS1 == {RW{1'b0}});
   assign cfg_fix_s  = cfg_zero_s ? NM1_MIN : CFG_NMINUS1;

   ejtag_dclk_phcnt #(
      .RW (RW)
   ) u_phcnt (
      .clk       (CLK),
      .rst_n     (RESET_D1_R_N),
      .active_i  (state_q != ST_IDLE),
      .run_i     (state_d != ST_IDLE),
      .nm1_cur_i (nm1_q),
      .nm1_nxt_i (nm1_d),
      .wrap_o    (wrap_s),
      .dclk_o    (EJT_DCLK_R),
      .dren_o    (EJT_DREN_R)
   );

   // Next-state, ratio/pending and period-count logic.
   always_comb begin
      state_d = state_q;
      nm1_d   = nm1_q;
      pval_d  = pval_q;
      pend_d  = pend_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      pcnt_d  = pcnt_q;

      case (state_q)
         ST_IDLE: begin
            if (EN) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Dropping EN exactly on the wrap edge has nothing left to drain.
            if (!EN && wrap_s) begin
               state_d = ST_IDLE;
            end else if (!EN) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (EN) begin
               state_d = ST_RUN;
            end else if (wrap_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (CFG_LOAD && cfg_zero_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      // A load on the wrap edge bypasses the pending register and wins over
      // an older pending value; otherwise a pending value applies at the next
      // boundary (wrap, or any idle edge).
      if (wrap_s && CFG_LOAD) begin
         nm1_d  = cfg_fix_s;
         pend_d = 1'b0;
         ack_d  = 1'b1;
      end else if (pend_q && (wrap_s || (state_q == ST_IDLE))) begin
         nm1_d  = pval_q;
         ack_d  = 1'b1;
         if (CFG_LOAD) begin
            pend_d = 1'b1;
            pval_d = cfg_fix_s;
         end else begin
            pend_d = 1'b0;
         end
      end else if (CFG_LOAD) begin
         pend_d = 1'b1;
         pval_d = cfg_fix_s;
      end else begin
         pend_d = pend_q;
      end

      if (wrap_s) begin
         pcnt_d = pcnt_q + CNT_ONE;
      end else begin
         pcnt_d = pcnt_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Generator state machine and status registers.
   always_ff @(posedge CLK) begin
      if (!RESET_D1_R_N) begin
         state_q <= ST_IDLE;
         nm1_q   <= RST_NMINUS1;
         pval_q  <= {RW{1'b0}};
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         pcnt_q  <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         nm1_q   <= nm1_d;
         pval_q  <= pval_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign CFG_ACK_R    = ack_q;
   assign CFG_ERR_R    = err_q;
   assign BUSY_R       = busy_q;
   assign PERIOD_CNT_R = pcnt_q;

endmodule
